// File: rtl/imem_loader_if.sv
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte-stream input and instruction-memory write bus of the loader
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;

    // Loader side: consumes the byte stream, drives the memory write port
    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    // Environment side: byte source and instruction memory
    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Framed byte-stream loader for the 256x32 instruction memory;
//                holds the CPU in reset until a frame passes its XOR checksum
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter bit          BIG_ENDIAN     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    imem_loader_if.master      bus,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_err,
    output logic [8:0]         words_loaded
);

    localparam int                 c_TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [8:0]           r_count_n;
    logic [8:0]           r_words;
    logic [1:0]           r_bidx;
    logic [31:0]          r_word;
    logic [7:0]           r_acc;
    logic [c_TMO_W-1:0]   r_tmo;
    logic [7:0]           r_mem_addr;
    logic [31:0]          r_mem_wdata;
    logic                 r_cpu_hold;
    logic                 r_done;
    logic                 r_err;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_is_sync;
    logic                 w_tmo_active;
    logic                 w_timed_out;
    logic [31:0]          w_word_shift;
    logic [8:0]           w_words_inc;

    assign w_ready      = (r_state != S_WRITE);
    assign w_accept     = bus.rx_valid && w_ready;
    assign w_is_sync    = (bus.rx_data == SYNC_BYTE);
    assign w_tmo_active = (r_state == S_COUNT) || (r_state == S_DATA) || (r_state == S_CHECK);
    // An accepted byte in the expiry cycle takes priority over the timeout
    assign w_timed_out  = w_tmo_active && !w_accept && (r_tmo == c_TMO_MAX);
    assign w_word_shift = BIG_ENDIAN ? {r_word[23:0], bus.rx_data}
                                     : {bus.rx_data, r_word[31:8]};
    assign w_words_inc  = r_words + 9'd1;

    assign bus.rx_ready  = w_ready;
    assign bus.mem_we    = (r_state == S_WRITE);
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign cpu_hold      = r_cpu_hold;
    assign load_done     = r_done;
    assign load_err      = r_err;
    assign words_loaded  = r_words;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_accept && w_is_sync) begin
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (w_accept) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept && (r_bidx == 2'd3)) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_next = (w_words_inc == r_count_n) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (w_accept) begin
                    w_state_next = (bus.rx_data == r_acc) ? S_DONE : S_ERROR;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_timed_out) begin
            w_state_next = S_ERROR;
        end
    end

    // The word counter doubles as the write address; N=256 ends at 8'hFF
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_n   <= '0;
            r_words     <= '0;
            r_bidx      <= '0;
            r_word      <= '0;
            r_acc       <= '0;
            r_tmo       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_tmo <= (w_tmo_active && !w_accept && !w_timed_out) ? r_tmo + 1'b1 : '0;

            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (w_accept && w_is_sync) begin
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_cpu_hold <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (w_accept) begin
                        r_count_n <= (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
                        r_words   <= '0;
                        r_bidx    <= '0;
                        r_word    <= '0;
                        r_acc     <= '0;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word <= w_word_shift;
                        r_acc  <= r_acc ^ bus.rx_data;
                        r_bidx <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) begin
                            r_mem_addr  <= r_words[7:0];
                            r_mem_wdata <= w_word_shift;
                        end
                    end
                end
                S_WRITE: begin
                    r_words <= w_words_inc;
                end
                S_CHECK: begin
                    if (w_accept) begin
                        if (bus.rx_data == r_acc) begin
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_err      <= 1'b1;
                            r_cpu_hold <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (w_timed_out) begin
                r_err      <= 1'b1;
                r_cpu_hold <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
